// File: rtl/des_key_schedule_pkg.sv
// des_key_schedule_pkg: DES key-schedule widths, FSM encoding, PC1/PC2 permutations and shift table
package des_key_schedule_pkg;
  localparam int KEY_W = 64;
  localparam int HALF_W = 28;
  localparam int SK_W = 48;
  localparam int IDX_W = 5;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_GEN = 1'b1;
  // Tables use DES bit numbering: bit 1 is the MSB of the vector
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32};
  function automatic logic [2*HALF_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [2*HALF_W-1:0] r;
    for (int i = 0; i < 2*HALF_W; i++) r[2*HALF_W-1-i] = k[KEY_W-PC1_T[i]];
    return r;
  endfunction
  function automatic logic [SK_W-1:0] pc2(input logic [2*HALF_W-1:0] cd);
    logic [SK_W-1:0] r;
    for (int i = 0; i < SK_W; i++) r[SK_W-1-i] = cd[2*HALF_W-PC2_T[i]];
    return r;
  endfunction
  // 1 when SHIFT[round] is 2, 0 when it is 1 (rounds 1, 2, 9, 16)
  function automatic logic shift2(input logic [IDX_W-1:0] round);
    return !(round == 5'd1 || round == 5'd2 || round == 5'd9 || round == 5'd16);
  endfunction
endpackage

// File: rtl/des_ks_rot.sv
// des_ks_rot: combinational 28-bit rotate by 1 or 2, left or right
module des_ks_rot
  import des_key_schedule_pkg::*;
(
  input  logic [HALF_W-1:0] d,
  input  logic              dir,
  input  logic              amt2,
  output logic [HALF_W-1:0] q
);
  always_comb
    q = dir ? (amt2 ? {d[1:0], d[HALF_W-1:2]} : {d[0], d[HALF_W-1:1]})
            : (amt2 ? {d[HALF_W-3:0], d[HALF_W-1:HALF_W-2]} : {d[HALF_W-2:0], d[HALF_W-1]});
endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: streams DES subkeys K1..K16 (or K16..K1) one per cycle over valid/ready
module des_key_schedule
  import des_key_schedule_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             decrypt,
  input  logic [KEY_W-1:0] key,
  output logic             sk_valid,
  input  logic             sk_ready,
  output logic [SK_W-1:0]  sk,
  output logic [IDX_W-1:0] sk_idx,
  output logic             busy,
  output logic             done
);
  logic [0:0] state;
  logic [HALF_W-1:0] c, d, c_in, d_in, c_rot, d_rot;
  logic [2*HALF_W-1:0] pk;
  logic [3:0] cnt;
  logic mode, idle, hs, last, dir, amt2;
  // In IDLE the rotators see PC1(key) so the encrypt load can apply SHIFT[1]
  always_comb begin
    pk = pc1(key);
    idle = state == S_IDLE;
    hs = sk_valid & sk_ready;
    last = cnt == 4'd15;
    c_in = idle ? pk[2*HALF_W-1:HALF_W] : c;
    d_in = idle ? pk[HALF_W-1:0] : d;
    dir = !idle & mode;
    amt2 = !idle & (mode ? shift2(5'd16 - {1'b0, cnt}) : shift2({1'b0, cnt} + 5'd2));
  end
  des_ks_rot u_rot_c (.d(c_in), .dir(dir), .amt2(amt2), .q(c_rot));
  des_ks_rot u_rot_d (.d(d_in), .dir(dir), .amt2(amt2), .q(d_rot));
  assign sk_valid = state == S_GEN;
  assign busy = sk_valid;
  assign sk = pc2({c, d});
  assign sk_idx = {1'b0, mode ? 4'd15 - cnt : cnt};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      c <= '0;
      d <= '0;
      cnt <= '0;
      mode <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= hs & last;
      if (idle & start) begin
        state <= S_GEN;
        c <= decrypt ? c_in : c_rot;
        d <= decrypt ? d_in : d_rot;
        mode <= decrypt;
        cnt <= '0;
      end else if (hs) begin
        if (last) state <= S_IDLE;
        else begin
          c <= c_rot;
          d <= d_rot;
          cnt <= cnt + 4'd1;
        end
      end
    end
  end
endmodule
